// File: rtl/stream_seq_pkg.sv
// stream_seq_pkg: shared state encoding and datapath widths for the frame sequencer
package stream_seq_pkg;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_CNT_W = 32;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, DONE} state_t;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: period counter running 0..PERIOD-1 while enable is high, one-cycle tick on the last count
//   clk, reset (async, active-high), enable in; tick out (held low and counter parked at 0 while enable is low)
module frame_tick_gen #(
  parameter int PERIOD = 3125
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = enable && cnt == 16'(PERIOD - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!enable || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/stream_frame_sequencer.sv
// stream_frame_sequencer: fetches one frame of CHANNELS samples per frame tick and forwards them over valid/ready
//   source side: src_read strobe out; src_sample/src_num/src_valid in, presented the cycle after the strobe
//   sink side:   dst_sample/dst_chan/dst_first/dst_valid out, dst_ready in
//   status:      frame_count, busy, done, sticky err_overrun/err_underrun/err_seq; all outputs registered
//   STREAM_SEQ_CHECK_EN: when defined, src_num is checked against the expected channel and drives err_seq
module stream_frame_sequencer
  import stream_seq_pkg::*;
#(
  parameter int CHANNELS = 128,
  parameter int CHANNELS_PW2 = 7,
  parameter int FRAME_PERIOD = 3125
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_W-1:0]     src_sample,
  input  logic [SAMPLE_W-1:0]     src_num,
  input  logic                    src_valid,
  output logic                    src_read,
  output logic [SAMPLE_W-1:0]     dst_sample,
  output logic [CHANNELS_PW2-1:0] dst_chan,
  output logic                    dst_first,
  output logic                    dst_valid,
  input  logic                    dst_ready,
  output logic [FRAME_CNT_W-1:0]  frame_count,
  output logic                    busy,
  output logic                    done,
  output logic                    err_overrun,
  output logic                    err_underrun,
  output logic                    err_seq
);
  state_t state, state_n;
  logic [CHANNELS_PW2-1:0] ch_idx, ch_idx_n;
  logic tick, last, capture, frame_end, seq_bad;
  frame_tick_gen #(.PERIOD(FRAME_PERIOD)) u_tick (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .tick(tick)
  );
  assign last = ch_idx == CHANNELS_PW2'(CHANNELS - 1);
  assign capture = state == CAPTURE && src_valid;
  assign frame_end = state == PRESENT && dst_ready && last;
`ifdef STREAM_SEQ_CHECK_EN
  assign seq_bad = capture && src_num != SAMPLE_W'(ch_idx);
`else
  logic unused_num;
  assign unused_num = ^src_num;
  assign seq_bad = 1'b0;
`endif
  always_comb begin
    state_n = state;
    ch_idx_n = ch_idx;
    case (state)
      IDLE: begin
        state_n = tick ? FETCH : IDLE;
        ch_idx_n = tick ? '0 : ch_idx;
      end
      FETCH:   state_n = CAPTURE;
      CAPTURE: state_n = src_valid ? PRESENT : DONE;
      PRESENT: begin
        state_n = !dst_ready ? PRESENT : last ? IDLE : FETCH;
        ch_idx_n = (dst_ready && !last) ? ch_idx + CHANNELS_PW2'(1) : ch_idx;
      end
      default: state_n = DONE;
    endcase
  end
  // Outputs are decoded from the next state so they line up with the state register without a combinational tail.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ch_idx <= '0;
      src_read <= 1'b0;
      dst_valid <= 1'b0;
      dst_first <= 1'b0;
      dst_sample <= '0;
      dst_chan <= '0;
      frame_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_overrun <= 1'b0;
      err_underrun <= 1'b0;
      err_seq <= 1'b0;
    end else begin
      state <= state_n;
      ch_idx <= ch_idx_n;
      src_read <= state_n == FETCH;
      dst_valid <= state_n == PRESENT;
      busy <= state_n inside {FETCH, CAPTURE, PRESENT};
      done <= state_n == DONE;
      if (capture) begin
        dst_sample <= src_sample;
        dst_chan <= ch_idx;
        dst_first <= ch_idx == '0;
      end
      if (frame_end) frame_count <= frame_count + 1'b1;
      if (tick && state != IDLE && state != DONE) err_overrun <= 1'b1;
      if (state == CAPTURE && !src_valid && ch_idx != '0) err_underrun <= 1'b1;
      if (seq_bad) err_seq <= 1'b1;
    end
endmodule

// File: tb/tb_stream_frame_sequencer.sv
// tb_stream_frame_sequencer: randomized frame sequencing checked against a stream-level reference model
module tb_stream_frame_sequencer;
  localparam int CH = 4;
  localparam int P = 20;
  logic clk = 1'b0;
  logic reset, enable, src_valid, dst_ready;
  logic [15:0] src_sample, src_num;
  logic src_read, dst_first, dst_valid, busy, done, err_overrun, err_underrun, err_seq;
  logic [15:0] dst_sample;
  logic [1:0] dst_chan;
  logic [31:0] frame_count;
  int total = 0, bad = 0, cyc = 0, rd_ptr = 0;
  logic [31:0] sq[$];
  int rd_t[$];
  int hs_t[$];
  logic [15:0] hs_s[$];
  logic [1:0] hs_c[$];
  logic hs_f[$];

  stream_frame_sequencer #(.CHANNELS(CH), .CHANNELS_PW2(2), .FRAME_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src_sample(src_sample), .src_num(src_num), .src_valid(src_valid), .src_read(src_read),
    .dst_sample(dst_sample), .dst_chan(dst_chan), .dst_first(dst_first),
    .dst_valid(dst_valid), .dst_ready(dst_ready),
    .frame_count(frame_count), .busy(busy), .done(done),
    .err_overrun(err_overrun), .err_underrun(err_underrun), .err_seq(err_seq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Source model answers a read strobe with the next queued word; an empty queue reads as exhausted.
  always @(negedge clk) begin
    if (src_read) begin
      rd_t.push_back(cyc);
      if (rd_ptr < sq.size()) begin
        {src_num, src_sample} = sq[rd_ptr];
        src_valid = 1'b1;
      end else src_valid = 1'b0;
      rd_ptr++;
    end
    if (dst_valid && dst_ready) begin
      hs_s.push_back(dst_sample);
      hs_c.push_back(dst_chan);
      hs_f.push_back(dst_first);
      hs_t.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    dst_ready = 1'b1;
    src_valid = 1'b0;
    src_sample = '0;
    src_num = '0;
    step(2);
    sq.delete(); rd_t.delete(); hs_t.delete(); hs_s.delete(); hs_c.delete(); hs_f.delete();
    rd_ptr = 0;
    reset = 1'b0;
  endtask

  task automatic load(input int n, input int bad_idx, input int bad_num);
    for (int k = 0; k < n; k++)
      sq.push_back({(k == bad_idx) ? 16'(bad_num) : 16'(k % CH), 16'($urandom)});
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({src_read, dst_valid, dst_first, busy, done} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {src_read, dst_valid, dst_first, busy, done});
    end
    total++;
    if ({err_overrun, err_underrun, err_seq} !== 3'b0) begin
      bad++; $display("FAIL reset_err: got %b want 000", {err_overrun, err_underrun, err_seq});
    end
    total++;
    if ({dst_sample, dst_chan} !== 18'b0) begin
      bad++; $display("FAIL reset_data: got %h/%0d want 0/0", dst_sample, dst_chan);
    end
    total++;
    if (frame_count !== 32'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", frame_count);
    end
  endtask

  task automatic test_basic();
    int c0;
    do_reset();
    load(3 * CH, -1, 0);
    enable = 1'b1;
    c0 = cyc;
    step(75);
    enable = 1'b0;
    step(3);
    total++;
    if (rd_t.size() < 1 || rd_t[0] !== c0 + P) begin
      bad++; $display("FAIL basic_first_read: got %0d want %0d", rd_t.size() ? rd_t[0] - c0 : -1, P);
    end
    total++;
    if (hs_s.size() !== 3 * CH) begin
      bad++; $display("FAIL basic_count_hs: got %0d want %0d", hs_s.size(), 3 * CH);
    end
    for (int k = 0; k < hs_s.size() && k < 3 * CH; k++) begin
      total++;
      if ({hs_s[k], hs_c[k], hs_f[k], hs_t[k]} !== {sq[k][15:0], 2'(k % CH), k % CH == 0, c0 + P * (k / CH + 1) + 3 * (k % CH) + 2}) begin
        bad++;
        $display("FAIL basic_hs%0d: got s=%h c=%0d f=%0d t=%0d want s=%h c=%0d f=%0d t=%0d", k, hs_s[k], hs_c[k], hs_f[k], hs_t[k] - c0,
                 sq[k][15:0], k % CH, k % CH == 0, P * (k / CH + 1) + 3 * (k % CH) + 2);
      end
    end
    total++;
    if (frame_count !== 32'd3) begin
      bad++; $display("FAIL basic_frames: got %0d want 3", frame_count);
    end
    total++;
    if ({err_overrun, err_underrun, err_seq, done, busy} !== 5'b0) begin
      bad++; $display("FAIL basic_flags: got %b want 00000", {err_overrun, err_underrun, err_seq, done, busy});
    end
  endtask

  task automatic test_backpressure();
    int c0, stall, t;
    logic [17:0] held;
    do_reset();
    load(2 * CH, -1, 0);
    enable = 1'b1;
    c0 = cyc;
    stall = 0;
    held = '0;
    for (int i = 0; i < 55; i++) begin
      step(1);
      if (dst_valid && dst_chan == 2'd2 && frame_count == 0 && stall < 5) begin
        if (stall == 0) held = {dst_sample, dst_chan};
        else begin
          total++;
          if ({dst_sample, dst_chan} !== held) begin
            bad++; $display("FAIL bp_stable%0d: got %h want %h", stall, {dst_sample, dst_chan}, held);
          end
        end
        dst_ready = 1'b0;
        stall++;
      end else dst_ready = 1'b1;
    end
    enable = 1'b0;
    step(5);
    total++;
    if (hs_s.size() !== 2 * CH) begin
      bad++; $display("FAIL bp_count_hs: got %0d want %0d", hs_s.size(), 2 * CH);
    end
    for (int k = 0; k < hs_s.size() && k < 2 * CH; k++) begin
      t = c0 + P * (k / CH + 1) + 3 * (k % CH) + 2 + ((k == 2 || k == 3) ? 5 : 0);
      total++;
      if ({hs_s[k], hs_c[k], hs_t[k]} !== {sq[k][15:0], 2'(k % CH), t}) begin
        bad++;
        $display("FAIL bp_hs%0d: got s=%h c=%0d t=%0d want s=%h c=%0d t=%0d", k, hs_s[k], hs_c[k], hs_t[k] - c0, sq[k][15:0], k % CH, t - c0);
      end
    end
    total++;
    if ({frame_count, err_overrun} !== {32'd2, 1'b0}) begin
      bad++; $display("FAIL bp_frames: got %0d ov=%b want 2 ov=0", frame_count, err_overrun);
    end
  endtask

  task automatic test_overrun();
    int c0, stall;
    do_reset();
    load(2 * CH, -1, 0);
    enable = 1'b1;
    c0 = cyc;
    stall = 0;
    for (int i = 0; i < 75; i++) begin
      step(1);
      if (dst_valid && dst_chan == 2'd1 && frame_count == 0 && stall < 25) begin
        dst_ready = 1'b0;
        stall++;
      end else dst_ready = 1'b1;
      if (i == 35) begin
        total++;
        if (err_overrun !== 1'b0) begin
          bad++; $display("FAIL ov_early: got %b want 0", err_overrun);
        end
      end
    end
    enable = 1'b0;
    step(3);
    total++;
    if (err_overrun !== 1'b1) begin
      bad++; $display("FAIL ov_flag: got %b want 1", err_overrun);
    end
    total++;
    if (rd_t.size() !== 2 * CH || rd_t[CH] !== c0 + 3 * P) begin
      bad++; $display("FAIL ov_dropped_tick: got reads=%0d second_frame_at=%0d want reads=%0d at %0d", rd_t.size(),
                      rd_t.size() > CH ? rd_t[CH] - c0 : -1, 2 * CH, 3 * P);
    end
    for (int k = 0; k < hs_s.size() && k < 2 * CH; k++) begin
      total++;
      if ({hs_s[k], hs_c[k]} !== {sq[k][15:0], 2'(k % CH)}) begin
        bad++; $display("FAIL ov_hs%0d: got s=%h c=%0d want s=%h c=%0d", k, hs_s[k], hs_c[k], sq[k][15:0], k % CH);
      end
    end
    total++;
    if ({frame_count, done} !== {32'd2, 1'b0}) begin
      bad++; $display("FAIL ov_frames: got %0d done=%b want 2 done=0", frame_count, done);
    end
  endtask

  task automatic test_seq();
    logic exp_seq;
    do_reset();
    load(CH, 1, 5);
    enable = 1'b1;
    step(35);
    enable = 1'b0;
    step(2);
    exp_seq = 1'b0;
    for (int k = 0; k < rd_ptr && k < sq.size(); k++)
      if (sq[k][31:16] != 16'(k % CH)) exp_seq = 1'b1;
`ifndef STREAM_SEQ_CHECK_EN
    exp_seq = 1'b0;
`endif
    total++;
    if (err_seq !== exp_seq) begin
      bad++; $display("FAIL seq_flag: got %b want %b", err_seq, exp_seq);
    end
    total++;
    if (hs_s.size() !== CH || hs_c[1] !== 2'd1 || hs_s[1] !== sq[1][15:0]) begin
      bad++; $display("FAIL seq_forward: got n=%0d c=%0d s=%h want n=%0d c=1 s=%h", hs_s.size(), hs_c[1], hs_s[1], CH, sq[1][15:0]);
    end
    total++;
    if (frame_count !== 32'd1) begin
      bad++; $display("FAIL seq_frames: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_exhaust(input int n);
    logic exp_under;
    do_reset();
    load(n, -1, 0);
    exp_under = (n % CH) != 0;
    enable = 1'b1;
    step(P * (n / CH + 1) + 3 * (n % CH) + 10);
    total++;
    if ({done, busy, err_underrun} !== {1'b1, 1'b0, exp_under}) begin
      bad++; $display("FAIL exh%0d_flags: got done=%b busy=%b un=%b want done=1 busy=0 un=%b", n, done, busy, err_underrun, exp_under);
    end
    total++;
    if (frame_count !== 32'(n / CH) || hs_s.size() !== n) begin
      bad++; $display("FAIL exh%0d_frames: got %0d hs=%0d want %0d hs=%0d", n, frame_count, hs_s.size(), n / CH, n);
    end
    step(2 * P + 5);
    total++;
    if (rd_t.size() !== n + 1 || done !== 1'b1) begin
      bad++; $display("FAIL exh%0d_terminal: got reads=%0d done=%b want reads=%0d done=1", n, rd_t.size(), done, n + 1);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int budget;
    do_reset();
    load(2 * CH, -1, 0);
    enable = 1'b1;
    budget = 0;
    while (!(frame_count == 1 && dst_valid) && budget < 200) begin
      step(1);
      budget++;
    end
    total++;
    if (budget >= 200) begin
      bad++; $display("FAIL rmid_wait: got timeout want second-frame PRESENT");
    end
    reset = 1'b1;
    #1;
    total++;
    if ({dst_valid, src_read, busy, frame_count} !== 35'b0) begin
      bad++; $display("FAIL rmid_async: got valid=%b read=%b busy=%b count=%0d want 0/0/0/0", dst_valid, src_read, busy, frame_count);
    end
    do_reset();
    load(CH, -1, 0);
    enable = 1'b1;
    step(35);
    enable = 1'b0;
    step(2);
    total++;
    if (frame_count !== 32'd1 || hs_s.size() !== CH) begin
      bad++; $display("FAIL rmid_resume: got count=%0d hs=%0d want 1 hs=%0d", frame_count, hs_s.size(), CH);
    end
    for (int k = 0; k < hs_s.size() && k < CH; k++) begin
      total++;
      if ({hs_s[k], hs_c[k], hs_f[k]} !== {sq[k][15:0], 2'(k), k == 0}) begin
        bad++; $display("FAIL rmid_hs%0d: got s=%h c=%0d f=%b want s=%h c=%0d f=%b", k, hs_s[k], hs_c[k], hs_f[k], sq[k][15:0], k, k == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_seq();
    test_exhaust(6);
    test_exhaust(8);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_frame_sequencer.md
# stream_frame_sequencer

Controller that sequences a per-channel sample source, one frame of `CHANNELS` samples per frame tick, and forwards them downstream with a valid/ready handshake. It generates the frame tick internally and paces fetches from the source's one-shot read strobe. It checks channel ordering, flags overrun, underrun and sequence errors, and detects end of stream. It sits between the sample stream reader (simulation file source or acquisition front end) and the stimulation/processing datapath.

## Interface
- `CHANNELS`, 128: channels per frame.
- `CHANNELS_PW2`, 7: log2(CHANNELS); width of channel index.
- `FRAME_PERIOD`, 3125: clk cycles per frame tick; legal range 2..65535.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: permits new frame ticks.
- `src_sample` in 16: sample from source.
- `src_num` in 16: channel number carried with sample.
- `src_valid` in 1: source holds a sample; low after a fetch means exhausted.
- `src_read` out 1: one-cycle fetch strobe.
- `dst_sample` out 16: forwarded sample.
- `dst_chan` out CHANNELS_PW2: channel index (expected index, not `src_num`).
- `dst_first` out 1: high with channel 0 of a frame.
- `dst_valid` out 1 / `dst_ready` in 1: downstream handshake.
- `frame_count` out 32: completed frames, wraps.
- `busy` out 1: frame in progress.
- `done` out 1: source exhausted, sticky.
- `err_overrun`, `err_underrun`, `err_seq` out 1 each: sticky error flags.

## Operation
- Source protocol: `src_read` high for exactly one cycle fetches; the fetched word is on `src_*` the following cycle; `src_valid`=0 on that cycle means end of stream.
- Tick counter: counts 0..FRAME_PERIOD-1 while `enable`=1, tick when count==FRAME_PERIOD-1, then wraps to 0; held at 0 while `enable`=0.
- FSM states: IDLE, FETCH, CAPTURE, PRESENT, DONE.
  - IDLE: on tick go to FETCH, `ch_idx`=0.
  - FETCH: `src_read`=1 for this cycle only; go to CAPTURE.
  - CAPTURE: if `src_valid`=0, go to DONE, and set `err_underrun` if `ch_idx`!=0. Otherwise register the sample into the `dst_*` outputs, compare `src_num` with `ch_idx` (mismatch sets `err_seq`; sample still forwarded), go to PRESENT.
  - PRESENT: `dst_valid`=1, outputs stable until `dst_ready`. When `dst_ready` is high: if `ch_idx`==CHANNELS-1, increment `frame_count` and go to IDLE; otherwise increment `ch_idx` and go to FETCH.
  - DONE: terminal; `done`=1; ticks ignored until reset.
- Tick arriving in any state other than IDLE: the tick is dropped, `err_overrun` is set, and the current frame continues. No tick queueing.
- `enable` falling mid-frame: the current frame completes; no new ticks follow.
- `busy` = state in {FETCH, CAPTURE, PRESENT}.
- Reset values: `src_read`, `dst_valid`, `dst_first`, `busy`, `done` and all error flags are 0; `dst_sample`=0, `dst_chan`=0, `frame_count`=0; state IDLE; tick count 0.
- Reset mid-frame aborts immediately. The partial frame is not counted.

## Timing
- Tick seen in IDLE at cycle T: `src_read`=1 at T+1, capture at T+2, `dst_valid`=1 at T+3.
- Per sample: at least 3 cycles (FETCH, CAPTURE, PRESENT with `dst_ready`=1). Each cycle `dst_ready` is held low adds one cycle.
- Overrun-free operation requires FRAME_PERIOD ≥ 3*CHANNELS+1 with `dst_ready` tied high.
- `frame_count` updates in the cycle after the last handshake.
- All outputs are registered; no combinational path from `dst_ready` to `src_read`.

## Configuration
- `STREAM_SEQ_CHECK_EN` defined: `src_num` comparison is active and `err_seq` works as described.
- `STREAM_SEQ_CHECK_EN` undefined: `src_num` is ignored and `err_seq` is tied to 0. All other behaviour is identical.

## Structure
- Package `stream_seq_pkg`: FSM state enum, sample width constant (16), frame counter width (32).
- Sub-module `frame_tick_gen`: period counter with `enable`, producing a one-cycle `tick`.
- The FSM, capture registers and flags stay in the top module.

## Test plan
- CHANNELS=4, FRAME_PERIOD=20, source channel numbers 0..3 repeating, `dst_ready`=1 -> one frame every 20 cycles; `dst_chan` 0,1,2,3; `dst_first` on channel 0; `frame_count` 1,2,3; no error flags.
- Same setup, `dst_ready` low for 5 cycles on channel 2 -> `dst_sample` and `dst_chan` held stable; frame completes 5 cycles later.
- FRAME_PERIOD=8, CHANNELS=4 (needs 13 cycles per frame) -> `err_overrun`=1; every other tick is dropped; frames still complete in order.
- Source delivers channel number 5 at index 1 -> `err_seq`=1, `dst_chan`=1. With `STREAM_SEQ_CHECK_EN` undefined -> `err_seq` stays 0.
- Source exhausted after 6 samples (CHANNELS=4) -> `done`=1, `err_underrun`=1, `frame_count`=1. Exhaustion exactly on a frame boundary -> `done`=1, `err_underrun`=0.
- `reset` asserted while in PRESENT -> `dst_valid`=0 and `src_read`=0 asynchronously; `frame_count`=0; normal frames resume after reset is released.
